alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 27 ++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes yield zero.
import alu_pkg::*;

module alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result
);

    always_comb begin
        result = '0;
        case (op)
            OPCODE_LENGTH'(OP_AND): result = srca & srcb;
            OPCODE_LENGTH'(OP_OR):  result = srca | srcb;
            OPCODE_LENGTH'(OP_ADD): result = srca + srcb;
            OPCODE_LENGTH'(OP_XOR): result = srca ^ srcb;
            OPCODE_LENGTH'(OP_SUB): result = srca - srcb;
            OPCODE_LENGTH'(OP_EQ):  result = DATA_WIDTH'(srca == srcb);
            default:                result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU,
// one transaction in flight at a time.
import alu_pkg::*;

module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,
    output logic                     busy
);

    state_t                   state;
    state_t                   next_state;
    logic                     last_grant;
    logic                     grant_q;
    logic                     gnt;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    srca_q;
    logic [DATA_WIDTH-1:0]    srcb_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [DATA_WIDTH-1:0]    alu_result;

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca   (srca_q),
        .srcb   (srcb_q),
        .op     (op_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last_grant;
        else                          gnt = ~req0_valid;
        unique case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (grant_q ? rsp1_ready : rsp0_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            srca_q     <= '0;
            srcb_q     <= '0;
            op_q       <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                grant_q <= gnt;
                srca_q  <= gnt ? req1_srca : req0_srca;
                srcb_q  <= gnt ? req1_srcb : req0_srcb;
                op_q    <= gnt ? req1_op   : req0_op;
            end
            if (state == EXEC) begin
                result_q   <= alu_result;
                last_grant <= grant_q;
            end
        end
    end

    assign rsp0_valid  = (state == RESP) && !grant_q;
    assign rsp1_valid  = (state == RESP) && grant_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed vector bench for alu_arbiter.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_srca   (req0_srca),
        .req0_srcb   (req0_srcb),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_srca   (req1_srca),
        .req1_srcb   (req1_srcb),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (!r) begin
            req0_valid = 1'b1; req0_op = op;
            req0_srca = a;     req0_srcb = b;
        end else begin
            req1_valid = 1'b1; req1_op = op;
            req1_srca = a;     req1_srcb = b;
        end
    endtask

    task automatic do_op(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        drive(v.r, v.op, v.a, v.b);
        #1;
        chk({p, "_ready"}, v.r ? req1_ready : req0_ready, 1);
        chk({p, "_other_ready"}, v.r ? req0_ready : req1_ready, 0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({p, "_exec_busy"}, busy, 1);
        chk({p, "_exec_rsp"}, {rsp0_valid, rsp1_valid}, 0);
        tick;
        chk({p, "_rsp_valid"}, v.r ? rsp1_valid : rsp0_valid, 1);
        chk({p, "_rsp_other"}, v.r ? rsp0_valid : rsp1_valid, 0);
        chk({p, "_result"}, v.r ? rsp1_result : rsp0_result, v.exp);
        chk({p, "_other_result"}, v.r ? rsp0_result : rsp1_result, 0);
        tick;
        chk({p, "_idle_busy"}, busy, 0);
        chk({p, "_idle_rsp"}, {rsp0_valid, rsp1_valid}, 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_srca = 0; req0_srcb = 0; req0_op = 0;
        req1_srca = 0; req1_srcb = 0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;

        vecs.push_back('{0, 4'b0010, 32'd5, 32'd7, 32'd12});
        vecs.push_back('{1, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE});
        vecs.push_back('{0, 4'b1000, 32'd9, 32'd9, 32'd1});
        vecs.push_back('{1, 4'b1000, 32'd9, 32'd8, 32'd0});
        vecs.push_back('{0, 4'b1111, 32'd9, 32'd8, 32'd0});
        vecs.push_back('{1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
        vecs.push_back('{0, 4'b0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0});
        vecs.push_back('{1, 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
        vecs.push_back('{0, 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1});
        vecs.push_back('{1, 4'b0101, 32'd1, 32'd1, 32'd0});

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_result0", rsp0_result, 0);
        chk("rst_result1", rsp1_result, 0);
        tick;
        rst_n = 1'b1;
        tick;

        foreach (vecs[i]) do_op(i, vecs[i]);

        // both requesting continuously: grants alternate, req0 first
        do_reset;
        tick;
        req0_valid = 1'b1; req0_op = 4'b0010;
        req1_valid = 1'b1; req1_op = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = k % 2;
            req0_srca = k; req0_srcb = 32'd10;
            req1_srca = 32'd100; req1_srcb = k;
            #1;
            chk($sformatf("rr%0d_ready0", k), req0_ready, (g == 0));
            chk($sformatf("rr%0d_ready1", k), req1_ready, (g == 1));
            tick;
            tick;
            if (g == 0) begin
                chk($sformatf("rr%0d_valid", k), {rsp0_valid, rsp1_valid}, 2'b10);
                chk($sformatf("rr%0d_result", k), rsp0_result, k + 10);
            end else begin
                chk($sformatf("rr%0d_valid", k), {rsp0_valid, rsp1_valid}, 2'b01);
                chk($sformatf("rr%0d_result", k), rsp1_result, 100 - k);
            end
            tick;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;

        // response back-pressure
        rsp0_ready = 1'b0;
        drive(0, 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        #1;
        tick;
        req0_valid = 1'b0;
        tick;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), rsp0_valid, 1);
            chk($sformatf("hold%0d_result", k), rsp0_result, 32'hFF00_FF00);
            chk($sformatf("hold%0d_ready", k), {req0_ready, req1_ready}, 0);
            chk($sformatf("hold%0d_busy", k), busy, 1);
            tick;
        end
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        tick;
        chk("hold_release_busy", busy, 0);
        chk("hold_release_valid", rsp0_valid, 0);

        // reset while executing; last_grant is 0 beforehand
        drive(0, 4'b0010, 32'd1, 32'd1);
        #1;
        tick;
        chk("mid_exec_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("async_ready", {req0_ready, req1_ready}, 0);
        chk("async_result", rsp0_result, 0);
        req0_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dropped%0d_rsp", k), {rsp0_valid, rsp1_valid}, 0);
            tick;
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("post_rst_tie", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;

        // req1 pulsed during RESP must be ignored
        rsp0_ready = 1'b0;
        drive(0, 4'b0001, 32'd1, 32'd2);
        #1;
        tick;
        req0_valid = 1'b0;
        tick;
        chk("pulse_in_resp", rsp0_valid, 1);
        req1_valid = 1'b1;
        #1;
        chk("pulse_ready1", req1_ready, 0);
        tick;
        req1_valid = 1'b0;
        tick;
        rsp0_ready = 1'b1;
        tick;
        chk("pulse_idle", busy, 0);
        chk("pulse_no_rsp1", rsp1_valid, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("pulse_ptr_kept", {req0_ready, req1_ready}, 2'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
